// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding, counter
// widths and the constants that identify the halt syscall in ID.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   localparam int CYCLE_W = 32;
   localparam int EVT_W   = 16;

   // Halt is "syscall" (SPECIAL opcode, funct 0x0c) with $v0 == 10
   localparam logic [5:0]  OP_SPECIAL    = 6'h00;
   localparam logic [5:0]  FUNCT_SYSCALL = 6'h0c;
   localparam logic [31:0] V0_EXIT       = 32'd10;

   function automatic logic is_halt(input logic [5:0]  op,
                                    input logic [5:0]  funct,
                                    input logic [31:0] v0);
      return (op == OP_SPECIAL) && (funct == FUNCT_SYSCALL) && (v0 == V0_EXIT);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline controller bus: hazard/decode requests in, pipeline register
// enables/flushes and performance counters out.
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic               stall_req;
   logic               branch_taken;
   logic               halt_req;
   logic               go;
   logic               pc_en;
   logic               ifid_en;
   logic               ifid_flush;
   logic               idex_flush;
   logic               halted;
   logic [CYCLE_W-1:0] cycle_cnt;
   logic [EVT_W-1:0]   stall_cnt;
   logic [EVT_W-1:0]   branch_cnt;

   // Datapath / hazard side
   modport master (
      output stall_req, branch_taken, halt_req, go,
      input  pc_en, ifid_en, ifid_flush, idex_flush, halted,
      input  cycle_cnt, stall_cnt, branch_cnt
   );

   // Controller side
   modport slave (
      input  stall_req, branch_taken, halt_req, go,
      output pc_en, ifid_en, ifid_flush, idex_flush, halted,
      output cycle_cnt, stall_cnt, branch_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter with selectable saturate-at-all-ones or wrap-around behaviour.
module sat_counter #(
   parameter int W   = 16,
   parameter bit SAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count one per enabled cycle; a saturating counter parks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && !(SAT && (&count)))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: resolves branch / load-use / halt requests
// into PC and IF/ID/ID-EX controls, sequences halt -> drain -> halted -> resume,
// and keeps cycle, stall and branch counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input logic            clk,
   input logic            rst_n,
   pipeline_ctrl_if.slave bus
);

   localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_t        state;
   logic [DW-1:0] drain_cnt;
   logic          in_run;
   logic          take_br;
   logic          take_stall;
   logic          take_halt;

   // Request priority in RUN: branch (ID is wrong-path) > stall > halt
   assign in_run     = (state == ST_RUN);
   assign take_br    = in_run && bus.branch_taken;
   assign take_stall = in_run && !bus.branch_taken && bus.stall_req;
   assign take_halt  = in_run && !bus.branch_taken && !bus.stall_req && bus.halt_req;

   // Control FSM and drain countdown; drain_cnt==0 marks the last DRAIN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (take_halt) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0)
                  state <= ST_HALTED;
               else
                  drain_cnt <= drain_cnt - DW'(1);
            end
            ST_HALTED: begin
               if (bus.go)
                  state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Pipeline controls straight from state and requests; reset forces a full flush
   always_comb begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b1;
      bus.halted     = 1'b0;
      if (!rst_n) begin
         bus.ifid_flush = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.branch_taken) begin
                  bus.pc_en      = 1'b1;
                  bus.ifid_en    = 1'b1;
                  bus.ifid_flush = 1'b1;
               end else if (!bus.stall_req && !bus.halt_req) begin
                  bus.pc_en      = 1'b1;
                  bus.ifid_en    = 1'b1;
                  bus.idex_flush = 1'b0;
               end
            end
            ST_HALTED: bus.halted = 1'b1;
            default: ;
         endcase
      end
   end

   sat_counter #(.W(CYCLE_W), .SAT(1'b0)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state != ST_HALTED),
      .count (bus.cycle_cnt)
   );

   sat_counter #(.W(EVT_W), .SAT(1'b1)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (take_stall),
      .count (bus.stall_cnt)
   );

   sat_counter #(.W(EVT_W), .SAT(1'b1)) u_branch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (take_br),
      .count (bus.branch_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

   localparam int DRAIN_CYCLES = 3;

   logic clk = 1'b0;
   logic rst_n;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: cycles of drain left (0 = running), halted flag, counters
   int          m_drain;
   bit          m_halted;
   logic [31:0] m_cyc;
   int          m_stall;
   int          m_br;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_drain  = 0;
      m_halted = 1'b0;
      m_cyc    = '0;
      m_stall  = 0;
      m_br     = 0;
   endtask

   // Expected outputs from the model's mode and the current requests
   task automatic check_model();
      logic pc, ie, ifl, xfl, hl;
      if (!rst_n)          {pc, ie, ifl, xfl, hl} = 5'b00110;
      else if (m_halted)   {pc, ie, ifl, xfl, hl} = 5'b00011;
      else if (m_drain > 0){pc, ie, ifl, xfl, hl} = 5'b00010;
      else if (bus.branch_taken)                  {pc, ie, ifl, xfl, hl} = 5'b11110;
      else if (bus.stall_req || bus.halt_req)     {pc, ie, ifl, xfl, hl} = 5'b00010;
      else                                        {pc, ie, ifl, xfl, hl} = 5'b11000;
      cmp("pc_en",      32'(bus.pc_en),      32'(pc));
      cmp("ifid_en",    32'(bus.ifid_en),    32'(ie));
      cmp("ifid_flush", 32'(bus.ifid_flush), 32'(ifl));
      cmp("idex_flush", 32'(bus.idex_flush), 32'(xfl));
      cmp("halted",     32'(bus.halted),     32'(hl));
      cmp("cycle_cnt",  bus.cycle_cnt,       m_cyc);
      cmp("stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
      cmp("branch_cnt", 32'(bus.branch_cnt), 32'(m_br));
   endtask

   // Model update for one rising edge with the requests currently applied
   task automatic model_edge();
      if (!rst_n) return;
      if (m_halted) begin
         if (bus.go) m_halted = 1'b0;
      end else if (m_drain > 0) begin
         m_cyc   = m_cyc + 32'd1;
         m_drain = m_drain - 1;
         if (m_drain == 0) m_halted = 1'b1;
      end else begin
         m_cyc = m_cyc + 32'd1;
         if (bus.branch_taken)  m_br    = (m_br    < 65535) ? m_br + 1    : 65535;
         else if (bus.stall_req) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
         else if (bus.halt_req)  m_drain = DRAIN_CYCLES;
      end
   endtask

   // Apply requests mid-cycle and check everything against the model
   task automatic set(input bit s, input bit b, input bit h, input bit g);
      bus.stall_req    = s;
      bus.branch_taken = b;
      bus.halt_req     = h;
      bus.go           = g;
      #1;
      check_model();
   endtask

   // Advance one clock, landing 2 time units after the rising edge
   task automatic adv();
      model_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_rst(input logic v);
      rst_n = v;
      if (!v) model_reset();
   endtask

   initial begin
      bit rs, rb, rh, rg;
      bus.stall_req    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.halt_req     = 1'b0;
      bus.go           = 1'b0;
      drive_rst(1'b0);
      repeat (2) @(posedge clk);
      #2;

      // Reset values
      set(0, 0, 0, 0);
      cmp("rst_pc_en",      32'(bus.pc_en),      32'd0);
      cmp("rst_ifid_flush", 32'(bus.ifid_flush), 32'd1);
      cmp("rst_idex_flush", 32'(bus.idex_flush), 32'd1);
      cmp("rst_halted",     32'(bus.halted),     32'd0);
      cmp("rst_cycle_cnt",  bus.cycle_cnt,       32'd0);
      adv();
      drive_rst(1'b1);

      // 10 idle cycles
      for (int i = 0; i < 10; i++) begin
         set(0, 0, 0, 0);
         adv();
      end
      set(0, 0, 0, 0);
      cmp("idle_pc_en",     32'(bus.pc_en),      32'd1);
      cmp("idle_cycle_cnt", bus.cycle_cnt,       32'd10);
      cmp("idle_stall_cnt", 32'(bus.stall_cnt),  32'd0);
      cmp("idle_br_cnt",    32'(bus.branch_cnt), 32'd0);

      // Two-cycle load-use stall
      for (int i = 0; i < 2; i++) begin
         set(1, 0, 0, 0);
         cmp("stall_pc_en",      32'(bus.pc_en),      32'd0);
         cmp("stall_idex_flush", 32'(bus.idex_flush), 32'd1);
         adv();
      end
      set(0, 0, 0, 0);
      cmp("stall_cnt_2",   32'(bus.stall_cnt), 32'd2);
      cmp("stall_resume",  32'(bus.pc_en),     32'd1);

      // Branch wins over a simultaneous stall
      set(1, 1, 0, 0);
      cmp("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
      cmp("br_idex_flush", 32'(bus.idex_flush), 32'd1);
      cmp("br_pc_en",      32'(bus.pc_en),      32'd1);
      adv();
      set(0, 0, 0, 0);
      cmp("br_cnt_1",      32'(bus.branch_cnt), 32'd1);
      cmp("br_stall_hold", 32'(bus.stall_cnt),  32'd2);
      cmp("pre_halt_cyc",  bus.cycle_cnt,       32'd13);

      // Halt: three DRAIN cycles (go ignored there), then HALTED
      set(0, 0, 1, 0);
      cmp("halt_pc_en", 32'(bus.pc_en), 32'd0);
      adv();
      set(0, 0, 0, 1);
      cmp("drain1_halted", 32'(bus.halted), 32'd0);
      adv();
      set(0, 0, 0, 0);
      cmp("drain2_halted", 32'(bus.halted), 32'd0);
      adv();
      set(0, 0, 0, 0);
      cmp("drain3_halted", 32'(bus.halted), 32'd0);
      adv();
      set(0, 0, 0, 0);
      cmp("halted_set",    32'(bus.halted), 32'd1);
      cmp("halted_cyc",    bus.cycle_cnt,   32'd17);
      adv();
      set(0, 0, 0, 1);
      cmp("halted_cyc_hold", bus.cycle_cnt, 32'd17);
      cmp("halted_go_pc",    32'(bus.pc_en), 32'd0);
      adv();
      set(0, 0, 0, 0);
      cmp("resume_pc_en",  32'(bus.pc_en),  32'd1);
      cmp("resume_halted", 32'(bus.halted), 32'd0);
      cmp("resume_cyc",    bus.cycle_cnt,   32'd17);
      adv();

      // Stall counter saturation
      set(0, 0, 0, 0);
      force dut.u_stall_cnt.count = 16'hFFFD;
      #1;
      release dut.u_stall_cnt.count;
      m_stall = 16'hFFFD;
      for (int i = 0; i < 4; i++) begin
         set(1, 0, 0, 0);
         adv();
      end
      set(0, 0, 0, 0);
      cmp("stall_sat", 32'(bus.stall_cnt), 32'h0000FFFF);

      // Reset asserted mid-DRAIN
      set(0, 0, 1, 0);
      adv();
      set(0, 0, 0, 0);
      cmp("mid_drain_pc_en", 32'(bus.pc_en), 32'd0);
      drive_rst(1'b0);
      #1;
      check_model();
      cmp("rstd_pc_en",      32'(bus.pc_en),      32'd0);
      cmp("rstd_ifid_flush", 32'(bus.ifid_flush), 32'd1);
      cmp("rstd_halted",     32'(bus.halted),     32'd0);
      cmp("rstd_cyc",        bus.cycle_cnt,       32'd0);
      cmp("rstd_stall",      32'(bus.stall_cnt),  32'd0);
      adv();
      drive_rst(1'b1);
      set(0, 0, 0, 0);
      cmp("post_rst_pc_en",  32'(bus.pc_en),  32'd1);
      cmp("post_rst_halted", 32'(bus.halted), 32'd0);
      adv();
      set(0, 0, 0, 0);
      cmp("post_rst_cyc", bus.cycle_cnt, 32'd1);
      adv();

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 800; i++) begin
         rs = ($urandom_range(3) == 0);
         rb = ($urandom_range(5) == 0);
         rh = ($urandom_range(15) == 0);
         rg = ($urandom_range(3) == 0);
         if ($urandom_range(199) == 0) begin
            drive_rst(1'b0);
            set(rs, rb, rh, rg);
            adv();
            drive_rst(1'b1);
         end
         set(rs, rb, rh, rg);
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles to retire in-flight EX/MEM/WB instructions after halt.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stall_req, input, 1, load-use stall request from the hazard unit (ID vs EX load).
REQ-005 SHALL have port branch_taken, input, 1, branch or jump resolved taken in EX this cycle.
REQ-006 SHALL have port halt_req, input, 1, halt syscall decoded in ID (op 0x00, funct 0x0c, $v0 == 10).
REQ-007 SHALL have port go, input, 1, single-cycle resume pulse from the board.
REQ-008 SHALL have port pc_en, output, 1, PC register write enable.
REQ-009 SHALL have port ifid_en, output, 1, IF/ID register write enable.
REQ-010 SHALL have port ifid_flush, output, 1, IF/ID loads a NOP.
REQ-011 SHALL have port idex_flush, output, 1, ID/EX loads a bubble.
REQ-012 SHALL have port halted, output, 1, processor is in the HALTED state.
REQ-013 SHALL have port cycle_cnt, output, 32, count of non-halted cycles.
REQ-014 SHALL have port stall_cnt, output, 16, count of load-use stall cycles.
REQ-015 SHALL have port branch_cnt, output, 16, count of taken-branch flushes.

Function
REQ-016 SHALL implement the states RUN, DRAIN and HALTED.
REQ-017 In RUN with no request, SHALL drive pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
REQ-018 In RUN with branch_taken=1, SHALL drive pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, and SHALL increment branch_cnt.
REQ-019 branch_taken SHALL have priority: stall_req and halt_req in the same cycle are ignored, because the ID instruction is on the wrong path.
REQ-020 In RUN with stall_req=1 and branch_taken=0, SHALL drive pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, and SHALL increment stall_cnt.
REQ-021 stall_req SHALL take priority over halt_req, so halt is taken only once the stall clears.
REQ-022 In RUN with halt_req=1 and the other two requests 0, SHALL go to DRAIN, load the drain counter with DRAIN_CYCLES-1, drive pc_en=0, ifid_en=0, idex_flush=1 that cycle.
REQ-023 In DRAIN, SHALL drive pc_en=0, ifid_en=0, idex_flush=1.
REQ-024 In DRAIN, SHALL ignore stall_req, branch_taken and halt_req, and SHALL decrement the drain counter.
REQ-025 SHALL go from DRAIN to HALTED when the drain counter is 0.
REQ-026 In HALTED, SHALL drive halted=1, pc_en=0, ifid_en=0, idex_flush=1.
REQ-027 SHALL go from HALTED to RUN on go=1; the first RUN cycle follows the RUN rules.
REQ-028 go SHALL be ignored outside HALTED.
REQ-029 cycle_cnt SHALL increment in RUN and DRAIN, hold in HALTED, and wrap modulo 2^32.
REQ-030 stall_cnt and branch_cnt SHALL saturate at 0xFFFF.
REQ-031 Outputs SHALL be combinational from state and inputs, with no added latency; the state, drain counter and event counters are registered.

Reset
REQ-032 While rst_n=0, SHALL drive pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1 and halted=0, regardless of clk.
REQ-033 While rst_n=0, the state SHALL be RUN and all counters 0.
REQ-034 Reset asserted in DRAIN or HALTED SHALL abort the operation; after release the block SHALL be in RUN with counters 0.
REQ-035 The first rising edge after reset release SHALL follow the RUN rules.

Structure
REQ-036 The shared package SHALL hold the state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and the opcode/funct constants used for halt decode.
REQ-037 Event counting SHALL be one sub-module, sat_counter (width parameter, inc, saturate/wrap select), instantiated three times.

Verification
REQ-038 Reset, then 10 idle cycles -> pc_en=1, cycle_cnt=10, stall_cnt=0, branch_cnt=0.
REQ-039 stall_req high for 2 cycles -> pc_en=0 and idex_flush=1 on both cycles; stall_cnt=2; PC resumes on the third cycle.
REQ-040 branch_taken and stall_req high in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1; branch_cnt=1; stall_cnt unchanged.
REQ-041 halt_req pulse -> DRAIN for exactly 3 cycles, then halted=1; cycle_cnt stops; go pulse -> pc_en=1 next cycle.
REQ-042 Force stall_cnt near 0xFFFF and apply 3 more stalls -> stall_cnt holds at 0xFFFF.
REQ-043 rst_n low mid-DRAIN -> outputs take reset values immediately; after release the state is RUN and halted=0.
